melody_sequencer: RTL and testbench
===================================

Name: melody_sequencer

Overview:
Reader/player for the note ROM. It steps the ROM address at a fixed tempo and absorbs the ROM's one-cycle registered read latency. It decodes the ROM codes (0 = end of tune, 1 = rest, 2..127 = MIDI note) into a held pitch, gate and note-on strobe for the downstream tone generator. It sits between the note ROM and the phase-increment/sine stage.

Parameters:
TICK_DIV, 6000000, clock cycles per ROM step (tempo); legal range 4..2^24-1
ADDR_W, 9, ROM address width
NOTE_W, 8, ROM note width

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  1-cycle pulse; begin or restart the tune from address 0
stop  input  1  1-cycle pulse; abort playback
loop_en  input  1  1 = restart at address 0 on end code; sampled at end-code evaluation
rom_addr  output  ADDR_W  registered ROM address
rom_note  input  NOTE_W  ROM data; valid one clock after rom_addr changes
note_out  output  NOTE_W  current/last pitch (MIDI number)
gate  output  1  1 while a note sounds
note_on  output  1  1-cycle strobe on each new note attack
busy  output  1  1 from accepted start until IDLE
done  output  1  1-cycle strobe on natural (non-looping) end

Behaviour:
- Reset (async): state IDLE; rom_addr=0, note_out=0, gate=0, note_on=0, busy=0, done=0, tick counter=0.
- States: IDLE, PLAY, DONE.
- Step counter counts 0..TICK_DIV-1 and runs only in PLAY.
- Start accepted at edge E0:
  - rom_addr<=0, counter<=0, busy<=1, state PLAY.
  - ROM latches at E1; sequencer evaluates rom_note at E2.
  - Fixed latency: note_out/gate update 2 edges after rom_addr changes.
- Counter reaching TICK_DIV-1: rom_addr<=rom_addr+1 (mod 2^ADDR_W), counter<=0. Step k is issued at E0+k*TICK_DIV.
- Evaluation (one cycle, 2 edges after each address issue), by code:
  - 2..127 = note: note_out<=code, gate<=1. note_on<=1 if gate was 0 or code differs from note_out. Equal consecutive codes are legato-merged: no note_on, gate stays 1.
  - 1 = rest: gate<=0; note_out holds previous value; no note_on.
  - 0 = end, loop_en=1: gate<=0, note_out<=0; next address issued (at the next tick) is 0. Tempo grid is unbroken; the end step is one silent step.
  - 0 = end, loop_en=0: gate<=0, note_out<=0; state DONE for one cycle, which asserts done=1. Next edge: IDLE, busy<=0, rom_addr<=0.
  - 128..255: treated as rest.
- Address wrap: if step 2^ADDR_W-1 evaluates as a note or rest, the next issued address is 0 (wrap); playback continues.
- stop, any state: next edge gate<=0, note_on<=0, note_out<=0, busy<=0, state IDLE, rom_addr<=0. No done strobe. Any in-flight evaluation is discarded.
- start while busy: restart exactly as from IDLE (counter and address cleared, gate<=0 immediately). The first note of the restarted tune produces note_on.
- start and stop in the same cycle: stop wins.
- note_on is never high for 2 consecutive cycles.
- done and note_on are never asserted together.

Optional Feature:
MELODY_TRANSPOSE_EN
- Defined: adds input port transpose[4:0] (signed, -16..+15), sampled at each evaluation. note_out = code + transpose, saturated to 2..127. The legato compare uses the transposed value.
- Undefined: no transpose port; note_out = code.
- Rest and end decode always use the raw code.

Test Plan:
- TICK_DIV=8; ROM model {61,63,63,1,58,0}, loop_en=0; start at E0 -> rom_addr steps 0..5 at E0+8k:
  - note_out=61, gate=1, note_on at E2.
  - note_on at E10 (63); none at E18 (legato).
  - gate=0 at E26 (rest), note_out stays 63.
  - note_on at E34 (58).
  - done strobe after evaluation at E42; busy=0 one edge later.
- Same ROM, loop_en=1 -> after end step, address 0 issued at E48; note_on with 61 at E50; done never asserts.
- stop pulsed mid-note at step 2 -> gate=0, busy=0, rom_addr=0 next edge; no done; subsequent start replays from step 0.
- start and stop asserted together while playing -> IDLE, gate=0; start alone 3 cycles later restarts and note_on=61 appears 2 edges after acceptance.
- ROM with no 0 code, ADDR_W=3 -> address wraps 7->0 without done; continuous playback.
- With MELODY_TRANSPOSE_EN: transpose=+12 -> note_out=73 for code 61; transpose=-16 with code 10 -> note_out=2 (saturated); code 1 still rests.

Source files
------------

// File: rtl/melody_sequencer.sv
// melody_sequencer: steps a note ROM at a fixed tempo and decodes its codes
// (0 = end, 1 = rest, 2..127 = MIDI note) into a held pitch, gate and note-on strobe.
// Latency: note_out/gate/note_on update 2 edges after each rom_addr change (registered ROM + eval).
// Flow: no backpressure. start/stop are 1-cycle pulses and stop beats start.
// Ports: clk, reset (async, active-high); start, stop, loop_en controls; rom_addr/rom_note ROM
// interface; note_out, gate, note_on, busy, done towards the tone generator.
// Optional MELODY_TRANSPOSE_EN adds transpose[4:0] (signed), applied to notes with 2..127 saturation.
module melody_sequencer #(
    parameter int TICK_DIV = 6000000,
    parameter int ADDR_W   = 9,
    parameter int NOTE_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
`ifdef MELODY_TRANSPOSE_EN
    input  logic signed [4:0] transpose,
`endif
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [NOTE_W-1:0] rom_note,
    output logic [NOTE_W-1:0] note_out,
    output logic              gate,
    output logic              note_on,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DONE} state_t;

    localparam logic [23:0]       TICK_LAST = 24'(TICK_DIV - 1);
    localparam logic [NOTE_W-1:0] CODE_END  = '0;
    localparam logic [NOTE_W-1:0] CODE_REST = NOTE_W'(1);
    localparam logic [NOTE_W-1:0] CODE_MAX  = NOTE_W'(127);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] rom_addr_nx;
    logic [23:0]       cnt, cnt_nx;
    logic [NOTE_W-1:0] note_out_nx;
    logic              gate_nx, note_on_nx;
    // issue_d1/issue_d2 track an issued address through the ROM's read latency;
    // evaluation happens while issue_d2 is high.
    logic              issue_d1, issue_d1_nx, issue_d2, issue_d2_nx;
    // Set by a looping end code: the next tick issues address 0 instead of +1.
    logic              loop_pend, loop_pend_nx;

    logic              is_note;
    logic [NOTE_W-1:0] pitch;

    assign is_note = (rom_note > CODE_REST) && (rom_note <= CODE_MAX);

`ifdef MELODY_TRANSPOSE_EN
    localparam logic signed [NOTE_W+1:0] PITCH_MIN = 2;
    localparam logic signed [NOTE_W+1:0] PITCH_MAX = 127;
    logic signed [NOTE_W+1:0] pitch_sum;

    always_comb begin
        pitch_sum = $signed({2'b00, rom_note}) + $signed({{(NOTE_W-3){transpose[4]}}, transpose});
        if (pitch_sum < PITCH_MIN)
            pitch = PITCH_MIN[NOTE_W-1:0];
        else if (pitch_sum > PITCH_MAX)
            pitch = PITCH_MAX[NOTE_W-1:0];
        else
            pitch = pitch_sum[NOTE_W-1:0];
    end
`else
    assign pitch = rom_note;
`endif

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            rom_addr  <= '0;
            cnt       <= '0;
            note_out  <= '0;
            gate      <= 1'b0;
            note_on   <= 1'b0;
            issue_d1  <= 1'b0;
            issue_d2  <= 1'b0;
            loop_pend <= 1'b0;
        end else begin
            state     <= state_nx;
            rom_addr  <= rom_addr_nx;
            cnt       <= cnt_nx;
            note_out  <= note_out_nx;
            gate      <= gate_nx;
            note_on   <= note_on_nx;
            issue_d1  <= issue_d1_nx;
            issue_d2  <= issue_d2_nx;
            loop_pend <= loop_pend_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        rom_addr_nx  = rom_addr;
        cnt_nx       = cnt;
        note_out_nx  = note_out;
        gate_nx      = gate;
        note_on_nx   = 1'b0;
        issue_d1_nx  = 1'b0;
        issue_d2_nx  = issue_d1;
        loop_pend_nx = loop_pend;

        case (state)
            S_PLAY: begin
                if (cnt == TICK_LAST) begin
                    cnt_nx       = '0;
                    rom_addr_nx  = loop_pend ? '0 : rom_addr + 1'b1;
                    loop_pend_nx = 1'b0;
                    issue_d1_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end

                if (issue_d2) begin
                    if (is_note) begin
                        note_out_nx = pitch;
                        gate_nx     = 1'b1;
                        // Repeated pitch while sounding is legato: no new attack.
                        note_on_nx  = !gate || (pitch != note_out);
                    end else if (rom_note == CODE_END) begin
                        gate_nx     = 1'b0;
                        note_out_nx = '0;
                        if (loop_en)
                            loop_pend_nx = 1'b1;
                        else
                            state_nx = S_DONE;
                    end else begin
                        gate_nx = 1'b0;
                    end
                end
            end
            S_DONE: begin
                state_nx    = S_IDLE;
                rom_addr_nx = '0;
                cnt_nx      = '0;
            end
            default: begin
            end
        endcase

        if (stop) begin
            state_nx     = S_IDLE;
            rom_addr_nx  = '0;
            cnt_nx       = '0;
            note_out_nx  = '0;
            gate_nx      = 1'b0;
            note_on_nx   = 1'b0;
            issue_d1_nx  = 1'b0;
            issue_d2_nx  = 1'b0;
            loop_pend_nx = 1'b0;
        end else if (start) begin
            // Restart discards any in-flight evaluation; note_out holds so the
            // first note still strobes via the cleared gate.
            state_nx     = S_PLAY;
            rom_addr_nx  = '0;
            cnt_nx       = '0;
            gate_nx      = 1'b0;
            note_on_nx   = 1'b0;
            issue_d1_nx  = 1'b1;
            issue_d2_nx  = 1'b0;
            loop_pend_nx = 1'b0;
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with a registered ROM model (TICK_DIV=8, ADDR_W=3).
module tb_melody_sequencer;

    localparam int TICK_DIV = 8;
    localparam int ADDR_W   = 3;
    localparam int NOTE_W   = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              loop_en = 1'b0;
    logic [ADDR_W-1:0] rom_addr;
    logic [NOTE_W-1:0] rom_note = '0;
    logic [NOTE_W-1:0] note_out;
    logic              gate, note_on, busy, done;
`ifdef MELODY_TRANSPOSE_EN
    logic signed [4:0] transpose = '0;
`endif

    logic [NOTE_W-1:0] rom_mem [8];

    int n_checks = 0;
    int n_pass   = 0;
    int n_on     = 0;
    int n_done   = 0;
    int n_viol   = 0;
    logic prev_on = 1'b0;

    melody_sequencer #(.TICK_DIV(TICK_DIV), .ADDR_W(ADDR_W), .NOTE_W(NOTE_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .loop_en  (loop_en),
`ifdef MELODY_TRANSPOSE_EN
        .transpose(transpose),
`endif
        .rom_addr (rom_addr),
        .rom_note (rom_note),
        .note_out (note_out),
        .gate     (gate),
        .note_on  (note_on),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Registered ROM: data valid one clock after the address changes.
    always @(posedge clk) rom_note <= rom_mem[rom_addr];

    // Strobe bookkeeping sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (note_on) n_on++;
            if (done) n_done++;
            if (note_on && prev_on) n_viol++;
            if (note_on && done) n_viol++;
            prev_on = note_on;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // The edge consuming this pulse is E0.
    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
    endtask

    task automatic load_rom(input logic [NOTE_W-1:0] a0, a1, a2, a3, a4, a5, a6, a7);
        rom_mem[0] = a0; rom_mem[1] = a1; rom_mem[2] = a2; rom_mem[3] = a3;
        rom_mem[4] = a4; rom_mem[5] = a5; rom_mem[6] = a6; rom_mem[7] = a7;
    endtask

    initial begin
        load_rom(61, 63, 63, 1, 58, 0, 0, 0);
        cyc(3);
        chk("rst_addr", rom_addr, 0);
        chk("rst_note", note_out, 0);
        chk("rst_gate", gate, 0);
        chk("rst_on", note_on, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset = 1'b0;
        cyc(2);

        // Non-looping tune.
        pulse_start();
        chk("e0_addr", rom_addr, 0);
        chk("e0_busy", busy, 1);
        chk("e0_gate", gate, 0);
        cyc(2);
        chk("e2_note", note_out, 61);
        chk("e2_gate", gate, 1);
        chk("e2_on", note_on, 1);
        cyc(1);
        chk("e3_on", note_on, 0);
        cyc(5);
        chk("e8_addr", rom_addr, 1);
        cyc(2);
        chk("e10_note", note_out, 63);
        chk("e10_on", note_on, 1);
        cyc(8);
        chk("e18_legato_on", note_on, 0);
        chk("e18_gate", gate, 1);
        cyc(8);
        chk("e26_rest_gate", gate, 0);
        chk("e26_rest_note", note_out, 63);
        chk("e26_on", note_on, 0);
        cyc(8);
        chk("e34_note", note_out, 58);
        chk("e34_on", note_on, 1);
        cyc(8);
        chk("e42_done", done, 1);
        chk("e42_gate", gate, 0);
        chk("e42_note", note_out, 0);
        chk("e42_busy", busy, 1);
        cyc(1);
        chk("e43_done", done, 0);
        chk("e43_busy", busy, 0);
        chk("e43_addr", rom_addr, 0);
        cyc(3);

        // Looping tune: end step is one silent step, then address 0.
        loop_en = 1'b1;
        pulse_start();
        cyc(42);
        chk("loop_e42_gate", gate, 0);
        chk("loop_e42_done", done, 0);
        chk("loop_e42_busy", busy, 1);
        cyc(6);
        chk("loop_e48_addr", rom_addr, 0);
        cyc(2);
        chk("loop_e50_note", note_out, 61);
        chk("loop_e50_on", note_on, 1);
        cyc(2);
        chk("loop_e52_gate", gate, 1);

        // Start while busy: gate drops at once, tune replays.
        pulse_start();
        chk("rs_gate", gate, 0);
        chk("rs_addr", rom_addr, 0);
        chk("rs_busy", busy, 1);
        cyc(2);
        chk("rs_e2_on", note_on, 1);
        chk("rs_e2_note", note_out, 61);

        // Stop mid-note at step 2.
        cyc(18);
        chk("st_gate_before", gate, 1);
        pulse_stop();
        chk("st_gate", gate, 0);
        chk("st_busy", busy, 0);
        chk("st_addr", rom_addr, 0);
        chk("st_note", note_out, 0);
        cyc(20);
        chk("st_idle_gate", gate, 0);
        chk("st_idle_busy", busy, 0);
        pulse_start();
        cyc(2);
        chk("st_replay_on", note_on, 1);
        chk("st_replay_note", note_out, 61);

        // start and stop together: stop wins.
        cyc(3);
        start = 1'b1;
        stop = 1'b1;
        cyc(1);
        start = 1'b0;
        stop = 1'b0;
        chk("ss_busy", busy, 0);
        chk("ss_gate", gate, 0);
        chk("ss_addr", rom_addr, 0);
        cyc(2);
        pulse_start();
        chk("ss_rs_busy", busy, 1);
        cyc(1);
        chk("ss_e1_gate", gate, 0);
        chk("ss_e1_on", note_on, 0);
        cyc(1);
        chk("ss_e2_on", note_on, 1);
        chk("ss_e2_note", note_out, 61);

        // No end code: address wraps 7 -> 0 and play continues.
        pulse_stop();
        loop_en = 1'b0;
        load_rom(61, 62, 63, 64, 65, 66, 67, 68);
        cyc(2);
        pulse_start();
        cyc(56);
        chk("wr_e56_addr", rom_addr, 7);
        cyc(2);
        chk("wr_e58_note", note_out, 68);
        cyc(6);
        chk("wr_e64_addr", rom_addr, 0);
        chk("wr_e64_busy", busy, 1);
        cyc(2);
        chk("wr_e66_note", note_out, 61);
        chk("wr_e66_on", note_on, 1);
        chk("wr_e66_done", done, 0);
        pulse_stop();
        cyc(2);

        chk("cnt_note_on", n_on, 20);
        chk("cnt_done", n_done, 1);
        chk("strobe_rules", n_viol, 0);

`ifdef MELODY_TRANSPOSE_EN
        load_rom(61, 10, 1, 0, 0, 0, 0, 0);
        transpose = 5'sd12;
        pulse_start();
        cyc(2);
        chk("tr_up12", note_out, 73);
        transpose = -5'sd16;
        cyc(8);
        chk("tr_sat_low", note_out, 2);
        chk("tr_sat_gate", gate, 1);
        cyc(8);
        chk("tr_rest_gate", gate, 0);
        chk("tr_rest_note", note_out, 2);
        pulse_stop();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
